pipe_hazard_fwd_unit: RTL and testbench

//  Parametrised successor to the pipeline control register. Holds ID/EX, EX/MEM and MEM/WB

---
 rtl/pipe_hazard_fwd_unit.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_fwd_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_fwd_unit.sv
// Pipeline control registers (ID/EX, EX/MEM, MEM/WB) with RAW/load-use stall, ID-stage bypass
// and, when PIPE_FWD_EN is defined, EX-stage forwarding; otherwise interlock-only.
module pipe_hazard_fwd_unit #(
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int NUM_SRC     = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       waitrequest,
    input  logic                       id_valid,
    input  logic [NUM_SRC*RADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [NUM_SRC*DATA_W-1:0]  id_src_data,
    input  logic [RADDR_W-1:0]         id_dest,
    input  logic                       id_wen,
    input  logic                       id_is_load,
    input  logic                       id_flush,
    input  logic [DATA_W-1:0]          mem_result,
    input  logic [DATA_W-1:0]          wb_result,
    output logic                       stall,
    output logic                       ex_valid,
    output logic [RADDR_W-1:0]         ex_dest,
    output logic [NUM_SRC*DATA_W-1:0]  ex_src_data,
    output logic [NUM_SRC*2-1:0]       fwd_sel,
    output logic                       mem_valid,
    output logic [RADDR_W-1:0]         mem_dest,
    output logic                       mem_wen,
    output logic                       wb_valid,
    output logic [RADDR_W-1:0]         wb_dest,
    output logic                       wb_wen,
    output logic [STALL_CNT_W-1:0]     stall_count
);

    logic                       adv;
    logic                       capture;
    logic [NUM_SRC-1:0]         id_haz;
    logic [NUM_SRC*DATA_W-1:0]  ex_data_d, ex_data_q;
    logic [NUM_SRC*RADDR_W-1:0] ex_src_addr_q;
    logic [NUM_SRC-1:0]         ex_src_used_q;
    logic                       ex_valid_q, ex_wen_q, ex_is_load_q;
    logic [RADDR_W-1:0]         ex_dest_q;
    logic                       mem_valid_q, mem_wen_q, mem_is_load_q;
    logic [RADDR_W-1:0]         mem_dest_q;
    logic                       wb_valid_q, wb_wen_q;
    logic [RADDR_W-1:0]         wb_dest_q;
    logic [STALL_CNT_W-1:0]     stall_cnt_d, stall_cnt_q;

    assign adv = !waitrequest;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [RADDR_W-1:0] id_a;
            logic               ex_hit, wb_hit;
            assign id_a   = id_src_addr[gi*RADDR_W +: RADDR_W];
            assign ex_hit = ex_valid_q & ex_wen_q & (ex_dest_q != '0) & (ex_dest_q == id_a);
            assign wb_hit = wb_valid_q & wb_wen_q & (wb_dest_q != '0) & (wb_dest_q == id_a);
            // Register file writes and reads in the same cycle: take the write-back value.
            assign ex_data_d[gi*DATA_W +: DATA_W] = wb_hit ? wb_result
                                                           : id_src_data[gi*DATA_W +: DATA_W];
`ifdef PIPE_FWD_EN
            logic [RADDR_W-1:0] ex_a;
            logic               fwd_mem, fwd_wb;
            assign id_haz[gi] = id_src_used[gi] & ex_hit & ex_is_load_q;
            assign ex_a    = ex_src_addr_q[gi*RADDR_W +: RADDR_W];
            // Load data is not available in MEM; the load-use stall keeps this path unused.
            assign fwd_mem = ex_src_used_q[gi] & mem_valid_q & mem_wen_q & !mem_is_load_q
                           & (mem_dest_q != '0) & (mem_dest_q == ex_a);
            assign fwd_wb  = ex_src_used_q[gi] & wb_valid_q & wb_wen_q
                           & (wb_dest_q != '0) & (wb_dest_q == ex_a);
            assign fwd_sel[gi*2 +: 2] = fwd_mem ? 2'b10 : (fwd_wb ? 2'b01 : 2'b00);
            assign ex_src_data[gi*DATA_W +: DATA_W] =
                fwd_mem ? mem_result : (fwd_wb ? wb_result : ex_data_q[gi*DATA_W +: DATA_W]);
`else
            logic mem_hit;
            assign mem_hit = mem_valid_q & mem_wen_q & (mem_dest_q != '0) & (mem_dest_q == id_a);
            assign id_haz[gi] = id_src_used[gi] & (ex_hit | mem_hit);
            assign fwd_sel[gi*2 +: 2] = 2'b00;
            assign ex_src_data[gi*DATA_W +: DATA_W] = ex_data_q[gi*DATA_W +: DATA_W];
`endif
        end
    endgenerate

`ifndef PIPE_FWD_EN
    logic unused_fwd_state;
    assign unused_fwd_state = ^{mem_is_load_q, ex_src_addr_q, ex_src_used_q, mem_result};
`endif

    // Flush wins over a hazard: a killed instruction never stalls.
    assign stall   = id_valid & !id_flush & (|id_haz);
    assign capture = id_valid & !id_flush & !stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_wen_q      <= 1'b0;
            ex_is_load_q  <= 1'b0;
            ex_dest_q     <= '0;
            ex_src_addr_q <= '0;
            ex_src_used_q <= '0;
            ex_data_q     <= '0;
            mem_valid_q   <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_is_load_q <= 1'b0;
            mem_dest_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_wen_q      <= 1'b0;
            wb_dest_q     <= '0;
            stall_cnt_q   <= '0;
        end else if (adv) begin
            ex_valid_q    <= capture;
            ex_wen_q      <= id_wen & capture;
            ex_is_load_q  <= id_is_load & capture;
            ex_dest_q     <= id_dest;
            ex_src_addr_q <= id_src_addr;
            ex_src_used_q <= id_src_used & {NUM_SRC{capture}};
            ex_data_q     <= ex_data_d;
            mem_valid_q   <= ex_valid_q;
            mem_wen_q     <= ex_wen_q;
            mem_is_load_q <= ex_is_load_q;
            mem_dest_q    <= ex_dest_q;
            wb_valid_q    <= mem_valid_q;
            wb_wen_q      <= mem_wen_q;
            wb_dest_q     <= mem_dest_q;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_dest     = ex_dest_q;
    assign mem_valid   = mem_valid_q;
    assign mem_dest    = mem_dest_q;
    assign mem_wen     = mem_wen_q;
    assign wb_valid    = wb_valid_q;
    assign wb_dest     = wb_dest_q;
    assign wb_wen      = wb_wen_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Bench for pipe_hazard_fwd_unit: an architectural model (register file plus in-flight
// instructions) predicts the correct operand each EX instruction must see.
`timescale 1ns/1ps
module tb_pipe_hazard_fwd_unit;
    localparam int DW = 32, AW = 5, NS = 2, SCW = 4;
`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
    localparam int B2B_STALLS = 0, LU_STALLS = 1;
`else
    localparam bit FWD = 1'b0;
    localparam int B2B_STALLS = 2, LU_STALLS = 2;
`endif

    logic clk = 1'b0, reset_n = 1'b0, waitrequest = 1'b0, id_valid = 1'b0;
    logic [NS*AW-1:0] id_src_addr = '0;
    logic [NS-1:0]    id_src_used = '0;
    logic [NS*DW-1:0] id_src_data = '0;
    logic [AW-1:0]    id_dest = '0;
    logic             id_wen = 1'b0, id_is_load = 1'b0, id_flush = 1'b0;
    logic [DW-1:0]    mem_result = '0, wb_result = '0;
    logic             stall, ex_valid, mem_valid, mem_wen, wb_valid, wb_wen;
    logic [AW-1:0]    ex_dest, mem_dest, wb_dest;
    logic [NS*DW-1:0] ex_src_data;
    logic [NS*2-1:0]  fwd_sel;
    logic [SCW-1:0]   stall_count;

    pipe_hazard_fwd_unit #(.DATA_W(DW), .RADDR_W(AW), .NUM_SRC(NS), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_src_data(id_src_data),
        .id_dest(id_dest), .id_wen(id_wen), .id_is_load(id_is_load), .id_flush(id_flush),
        .mem_result(mem_result), .wb_result(wb_result), .stall(stall), .ex_valid(ex_valid),
        .ex_dest(ex_dest), .ex_src_data(ex_src_data), .fwd_sel(fwd_sel),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_wen(mem_wen),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_wen(wb_wen), .stall_count(stall_count));

    always #5 clk = ~clk;

    typedef struct {
        logic v, wen, ld;
        logic [AW-1:0] dest;
        logic [DW-1:0] res;
        logic [NS-1:0][AW-1:0] a;
        logic [NS-1:0] u;
        logic [NS-1:0][DW-1:0] opnd;
    } ins_t;

    ins_t id_i, ex_s, mem_s, wb_s;
    logic flush_i = 1'b0, wr_i = 1'b0;
    logic [DW-1:0] rf [32];
    int cnt_m = 0, checks = 0, errors = 0, cyc = 0;
    bit verbose = 1'b1;

    function automatic ins_t nop();
        ins_t n;
        n.v = 0; n.wen = 0; n.ld = 0; n.dest = '0; n.res = '0; n.a = '0; n.u = '0; n.opnd = '0;
        return n;
    endfunction

    function automatic ins_t mk(input logic [AW-1:0] d, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [NS-1:0] u,
                                input logic w, input logic ld, input logic [DW-1:0] r);
        ins_t n = nop();
        n.v = 1; n.dest = d; n.a[0] = a0; n.a[1] = a1; n.u = u; n.wen = w; n.ld = ld; n.res = r;
        return n;
    endfunction

    function automatic ins_t rand_ins();
        ins_t n = nop();
        n.v = ($urandom_range(0, 9) != 0);
        for (int i = 0; i < NS; i++) begin
            n.a[i] = AW'($urandom_range(0, 3));
            n.u[i] = ($urandom_range(0, 4) != 0);
        end
        n.dest = AW'($urandom_range(0, 3));
        n.wen  = ($urandom_range(0, 5) != 0);
        n.ld   = ($urandom_range(0, 3) == 0);
        n.res  = $urandom;
        return n;
    endfunction

    // An in-flight instruction writes architectural register a ($0 is never written).
    function automatic bit writes(input ins_t s, input logic [AW-1:0] a);
        return s.v && s.wen && (s.dest != 0) && (s.dest == a);
    endfunction

    function automatic bit exp_stall();
        bit h = 0;
        for (int i = 0; i < NS; i++)
            if (id_i.u[i]) begin
                if (FWD) h |= writes(ex_s, id_i.a[i]) && ex_s.ld;
                else     h |= writes(ex_s, id_i.a[i]) || writes(mem_s, id_i.a[i]);
            end
        return id_i.v && !flush_i && h;
    endfunction

    // Value the program order says register a holds for the instruction now in ID.
    function automatic logic [DW-1:0] arch_val(input logic [AW-1:0] a);
        if (a == 0)              return '0;
        if (writes(ex_s, a))     return ex_s.res;
        if (writes(mem_s, a))    return mem_s.res;
        if (writes(wb_s, a))     return wb_s.res;
        return rf[a];
    endfunction

    function automatic logic [1:0] exp_sel(input int i);
        if (!FWD || !ex_s.v || !ex_s.u[i]) return 2'b00;
        if (writes(mem_s, ex_s.a[i]) && !mem_s.ld) return 2'b10;
        if (writes(wb_s, ex_s.a[i])) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        ex_s = nop(); mem_s = nop(); wb_s = nop(); cnt_m = 0;
    endtask

    task automatic run_cycle(output bit consumed);
        bit   st;
        ins_t nx;
        @(negedge clk);
        cyc++;
        waitrequest = wr_i;
        id_valid = id_i.v; id_src_addr = id_i.a; id_src_used = id_i.u;
        id_dest = id_i.dest; id_wen = id_i.wen; id_is_load = id_i.ld; id_flush = flush_i;
        for (int i = 0; i < NS; i++) id_src_data[i*DW +: DW] = rf[id_i.a[i]];
        mem_result = (mem_s.v && !mem_s.ld) ? mem_s.res : $urandom;
        wb_result  = wb_s.v ? wb_s.res : $urandom;
        #1;
        st = exp_stall();
        checks++; if (stall !== st) begin errors++;
            $display("FAIL stall cyc=%0d got=%b exp=%b", cyc, stall, st); end
        checks++; if (stall_count !== SCW'(cnt_m)) begin errors++;
            $display("FAIL stall_count cyc=%0d got=%0d exp=%0d", cyc, stall_count, cnt_m); end
        checks++; if (ex_valid !== ex_s.v || (ex_s.v && ex_dest !== ex_s.dest)) begin errors++;
            $display("FAIL ex_ctl cyc=%0d got=%b/%0d exp=%b/%0d", cyc, ex_valid, ex_dest, ex_s.v, ex_s.dest); end
        checks++; if (mem_valid !== mem_s.v || mem_wen !== mem_s.wen || (mem_s.v && mem_dest !== mem_s.dest)) begin
            errors++;
            $display("FAIL mem_ctl cyc=%0d got=%b%b/%0d exp=%b%b/%0d", cyc, mem_valid, mem_wen, mem_dest,
                     mem_s.v, mem_s.wen, mem_s.dest); end
        checks++; if (wb_valid !== wb_s.v || wb_wen !== wb_s.wen || (wb_s.v && wb_dest !== wb_s.dest)) begin
            errors++;
            $display("FAIL wb_ctl cyc=%0d got=%b%b/%0d exp=%b%b/%0d", cyc, wb_valid, wb_wen, wb_dest,
                     wb_s.v, wb_s.wen, wb_s.dest); end
        for (int i = 0; i < NS; i++) begin
            checks++; if (fwd_sel[i*2 +: 2] !== exp_sel(i)) begin errors++;
                $display("FAIL fwd_sel%0d cyc=%0d got=%b exp=%b", i, cyc, fwd_sel[i*2 +: 2], exp_sel(i)); end
            if (ex_s.v && ex_s.u[i]) begin
                checks++; if (ex_src_data[i*DW +: DW] !== ex_s.opnd[i]) begin errors++;
                    $display("FAIL operand%0d cyc=%0d got=%h exp=%h", i, cyc, ex_src_data[i*DW +: DW],
                             ex_s.opnd[i]); end
            end
        end
        if (verbose)
            $display("cyc=%0d id_v=%b flush=%b wr=%b stall=%b ex_v=%b mem_v=%b wb_v=%b fwd=%b cnt=%0d",
                     cyc, id_valid, id_flush, waitrequest, stall, ex_valid, mem_valid, wb_valid,
                     fwd_sel, stall_count);
        consumed = 1'b0;
        if (!wr_i) begin
            consumed = !st;
            if (st && cnt_m < (2**SCW - 1)) cnt_m++;
            nx = nop();
            if (id_i.v && !flush_i && !st) begin
                nx = id_i;
                for (int i = 0; i < NS; i++) nx.opnd[i] = arch_val(id_i.a[i]);
            end
            if (wb_s.v && wb_s.wen && wb_s.dest != 0) rf[wb_s.dest] = wb_s.res;
            wb_s = mem_s; mem_s = ex_s; ex_s = nx;
        end
    endtask

    task automatic drain(input int n);
        bit c;
        id_i = nop(); flush_i = 0; wr_i = 0;
        repeat (n) run_cycle(c);
    endtask

    task automatic issue(input ins_t ins, output int stalls);
        bit c = 0;
        int k = 0;
        stalls = 0; id_i = ins; flush_i = 0; wr_i = 0;
        while (!c && k < 8) begin
            run_cycle(c);
            if (stall === 1'b1) stalls++;
            k++;
        end
        checks++; if (!c) begin errors++;
            $display("FAIL issue_timeout cyc=%0d got=stuck exp=accepted", cyc); end
    endtask

    task automatic test_reset();
        id_valid = 0; waitrequest = 0; reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if ({ex_valid, mem_valid, wb_valid, mem_wen, wb_wen} !== 5'b0) begin errors++;
            $display("FAIL reset_valids got=%b exp=00000", {ex_valid, mem_valid, wb_valid, mem_wen, wb_wen}); end
        checks++; if ({ex_dest, mem_dest, wb_dest} !== '0 || stall_count !== '0) begin errors++;
            $display("FAIL reset_dests got=%0d/%0d/%0d/%0d exp=0", ex_dest, mem_dest, wb_dest, stall_count); end
        checks++; if (stall !== 1'b0 || fwd_sel !== '0 || ex_src_data !== '0) begin errors++;
            $display("FAIL reset_comb got=%b/%b/%h exp=0", stall, fwd_sel, ex_src_data); end
        model_reset();
        reset_n = 1;
        drain(1);
    endtask

    task automatic test_back_to_back();
        int st;
        bit c;
        logic [DW-1:0] r1 = 32'h1234_5678;
        issue(mk(5'd3, 5'd1, 5'd2, 2'b11, 1, 0, r1), st);
        issue(mk(5'd4, 5'd3, 5'd3, 2'b11, 1, 0, 32'h0), st);
        checks++; if (st !== B2B_STALLS) begin errors++;
            $display("FAIL b2b_stalls got=%0d exp=%0d", st, B2B_STALLS); end
        id_i = nop(); run_cycle(c);
        checks++; if (fwd_sel !== (FWD ? 4'b1010 : 4'b0000)) begin errors++;
            $display("FAIL b2b_fwd_sel got=%b exp=%b", fwd_sel, FWD ? 4'b1010 : 4'b0000); end
        checks++; if (ex_src_data !== {r1, r1}) begin errors++;
            $display("FAIL b2b_operand got=%h exp=%h", ex_src_data, {r1, r1}); end
        checks++; if (stall_count !== SCW'(B2B_STALLS)) begin errors++;
            $display("FAIL b2b_count got=%0d exp=%0d", stall_count, B2B_STALLS); end
        drain(4);
    endtask

    task automatic test_load_use();
        int st;
        bit c;
        logic [DW-1:0] ld = 32'hCAFE_0005;
        issue(mk(5'd5, 5'd1, 5'd0, 2'b01, 1, 1, ld), st);
        issue(mk(5'd6, 5'd5, 5'd0, 2'b11, 1, 0, 32'h66), st);
        checks++; if (st !== LU_STALLS) begin errors++;
            $display("FAIL lu_stalls got=%0d exp=%0d", st, LU_STALLS); end
        checks++; if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
        id_i = nop(); run_cycle(c);
        checks++; if (fwd_sel[1:0] !== (FWD ? 2'b01 : 2'b00) || ex_src_data[DW-1:0] !== ld) begin errors++;
            $display("FAIL lu_operand got=%b/%h exp=%b/%h", fwd_sel[1:0], ex_src_data[DW-1:0],
                     FWD ? 2'b01 : 2'b00, ld); end
        drain(4);
    endtask

    task automatic test_zero_reg();
        int st;
        bit c;
        issue(mk(5'd0, 5'd1, 5'd2, 2'b11, 1, 0, 32'hDEAD_BEEF), st);
        issue(mk(5'd7, 5'd0, 5'd0, 2'b11, 1, 0, 32'h7), st);
        checks++; if (st !== 0) begin errors++; $display("FAIL zero_stalls got=%0d exp=0", st); end
        id_i = nop(); run_cycle(c);
        checks++; if (fwd_sel !== 4'b0000 || ex_src_data !== '0) begin errors++;
            $display("FAIL zero_operand got=%b/%h exp=0000/0", fwd_sel, ex_src_data); end
        drain(4);
    endtask

    task automatic test_waitrequest();
        int st;
        bit c;
        int c0;
        issue(mk(5'd5, 5'd2, 5'd0, 2'b01, 1, 1, 32'hABCD_0001), st);
        id_i = mk(5'd6, 5'd5, 5'd1, 2'b11, 1, 0, 32'h6); wr_i = 1;
        run_cycle(c);
        c0 = int'(stall_count);
        run_cycle(c); run_cycle(c);
        checks++; if (stall !== 1'b1 || stall_count !== SCW'(c0) || ex_valid !== 1'b1 || ex_dest !== 5'd5) begin
            errors++;
            $display("FAIL freeze got=%b/%0d/%b/%0d exp=1/%0d/1/5", stall, stall_count, ex_valid, ex_dest, c0); end
        wr_i = 0;
        issue(id_i, st);
        checks++; if (stall_count !== SCW'(c0 + LU_STALLS)) begin errors++;
            $display("FAIL freeze_count got=%0d exp=%0d", stall_count, c0 + LU_STALLS); end
        drain(4);
    endtask

    task automatic test_flush();
        int st;
        bit c;
        issue(mk(5'd5, 5'd1, 5'd0, 2'b01, 1, 1, 32'h55), st);
        id_i = mk(5'd6, 5'd5, 5'd5, 2'b11, 1, 0, 32'h6); flush_i = 1;
        run_cycle(c);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall); end
        id_i = nop(); flush_i = 0; run_cycle(c);
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_bubble got=%b exp=0", ex_valid); end
        drain(4);
    endtask

    task automatic test_saturation();
        int st;
        repeat (18) begin
            issue(mk(5'd2, 5'd1, 5'd0, 2'b01, 1, 1, $urandom), st);
            issue(mk(5'd3, 5'd2, 5'd0, 2'b01, 1, 0, $urandom), st);
        end
        checks++; if (stall_count !== {SCW{1'b1}}) begin errors++;
            $display("FAIL saturate got=%0d exp=%0d", stall_count, 2**SCW - 1); end
        drain(4);
    endtask

    task automatic test_random();
        bit c = 1;
        verbose = 0;
        for (int n = 0; n < 3000; n++) begin
            if (c) begin
                id_i = rand_ins();
                flush_i = ($urandom_range(0, 9) == 0);
            end else if (!wr_i) begin
                flush_i = ($urandom_range(0, 9) == 0);
            end
            wr_i = ($urandom_range(0, 6) == 0);
            run_cycle(c);
        end
        verbose = 1;
        drain(4);
    endtask

    task automatic test_async_reset();
        int st;
        issue(mk(5'd1, 5'd2, 5'd3, 2'b11, 1, 0, $urandom), st);
        issue(mk(5'd2, 5'd0, 5'd0, 2'b00, 1, 0, $urandom), st);
        issue(mk(5'd3, 5'd0, 5'd0, 2'b00, 1, 0, $urandom), st);
        waitrequest = 1; #1;
        reset_n = 0; #1;
        checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000 || stall_count !== '0) begin errors++;
            $display("FAIL async_reset got=%b/%0d exp=000/0", {ex_valid, mem_valid, wb_valid}, stall_count); end
        model_reset();
        id_valid = 0;
        @(negedge clk);
        reset_n = 1;
        drain(3);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? '0 : $urandom;
        id_i = nop(); model_reset();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_zero_reg();
        test_waitrequest();
        test_flush();
        test_saturation();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
